// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and its sequence-checker benches.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } seq_state_e;

  localparam logic [3:0] SEQ_1101 = 4'b1101;

endpackage

// File: rtl/seq_shreg.sv
// Parallel-load, MSB-out left-shift register. nxt_o is the MSB the register will hold after
// the coming edge, so the owner can register it straight into its own output flop.
module seq_shreg #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] din_i,
  output logic         nxt_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = din_i;
    end else if (shift_i) begin
      q_d = {q_q[W-2:0], 1'b0};
    end
  end

  assign nxt_o = q_d[W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB-first, rpt times,
// with an optional idle gap between frames. All outputs are registered.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] rpt,
  input  logic [GAP_W-1:0] gap,
  output logic             dout,
  output logic             dvalid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned IdxW = $clog2(PAT_W);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PAT_W - 1);

  seq_state_e       state_q, state_d;
  logic [IdxW-1:0]  bit_idx_q, bit_idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] frame_inc;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sr_load, sr_shift, sr_nxt;
  logic [PAT_W-1:0] sr_din;

  seq_shreg #(
    .W (PAT_W)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .din_i   (sr_din),
    .nxt_o   (sr_nxt)
  );

  assign frame_inc = frame_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    rpt_d       = rpt_q;
    frame_cnt_d = frame_cnt_q;
    pat_d       = pat_q;
    dvalid_d    = dvalid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_din      = pat_q;

    unique case (state_q)
      IDLE: begin
        dvalid_d = 1'b0;
        busy_d   = 1'b0;
        // abort outranks start, so a simultaneous pair starts nothing
        if (start && !abort) begin
          pat_d       = pattern;
          rpt_d       = (rpt == '0) ? CNT_W'(1) : rpt;
          gap_d       = gap;
          frame_cnt_d = '0;
          bit_idx_d   = '0;
          sr_load     = 1'b1;
          sr_din      = pattern;
          dvalid_d    = 1'b1;
          busy_d      = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d  = IDLE;
          dvalid_d = 1'b0;
          busy_d   = 1'b0;
        end else if (bit_idx_q != LastIdx) begin
          bit_idx_d = bit_idx_q + 1'b1;
          sr_shift  = 1'b1;
        end else begin
          frame_cnt_d = frame_inc;
          bit_idx_d   = '0;
          if (frame_inc == rpt_q) begin
            state_d  = IDLE;
            dvalid_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else if (gap_q == '0) begin
            sr_load = 1'b1;
          end else begin
            // down-counter: gap_q idle cycles, the last one when it reads zero
            state_d   = GAP;
            gap_cnt_d = gap_q - 1'b1;
            dvalid_d  = 1'b0;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d  = IDLE;
          dvalid_d = 1'b0;
          busy_d   = 1'b0;
        end else if (gap_cnt_q == '0) begin
          state_d  = SHIFT;
          sr_load  = 1'b1;
          dvalid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        dvalid_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Line is forced low whenever no pattern bit is presented.
  assign dout_d = dvalid_d & sr_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      rpt_q       <= '0;
      frame_cnt_q <= '0;
      pat_q       <= '0;
      dout_q      <= 1'b0;
      dvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      rpt_q       <= rpt_d;
      frame_cnt_q <= frame_cnt_d;
      pat_q       <= pat_d;
      dout_q      <= dout_d;
      dvalid_q    <= dvalid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dout      = dout_q;
  assign dvalid    = dvalid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: hand-computed serial waveforms plus a 1101 loopback checker.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] pattern;
  logic [7:0] rpt;
  logic [3:0] gap;
  logic       dout;
  logic       dvalid;
  logic       busy;
  logic       done;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] dv, vv, dn, bz, det_v, exp_det;
  int          det_cnt;
  int          done_at;

  seq_pattern_tx #(
    .PAT_W (4),
    .CNT_W (8),
    .GAP_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .rpt       (rpt),
    .gap       (gap),
    .dout      (dout),
    .dvalid    (dvalid),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 1101 sequence checker on the raw line; det_q pulses one cycle after the last 1.
  logic [2:0] hist_q;
  logic       det_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      det_q  <= 1'b0;
    end else begin
      hist_q <= {hist_q[1:0], dout};
      det_q  <= ({hist_q, dout} == SEQ_1101);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after E0 (first bit visible).
  task automatic start_burst(input logic [3:0] p, input logic [7:0] r, input logic [3:0] g);
    pattern = p;
    rpt     = r;
    gap     = g;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Samples n cycles, first cycle ends up in the most significant used bit.
  task automatic capture(input int n, output logic [31:0] d, output logic [31:0] v,
                         output logic [31:0] o, output logic [31:0] b);
    d = '0; v = '0; o = '0; b = '0;
    for (int i = 0; i < n; i++) begin
      d = {d[30:0], dout};
      v = {v[30:0], dvalid};
      o = {o[30:0], done};
      b = {b[30:0], busy};
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = '0; rpt = '0; gap = '0;
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_dout", 32'(dout), 0);
    check_eq("rst_dvalid", 32'(dvalid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_frame_cnt", 32'(frame_cnt), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single frame
    start_burst(SEQ_1101, 8'd1, 4'd0);
    capture(5, dv, vv, dn, bz);
    check_eq("single_dout", dv, 32'b11010);
    check_eq("single_dvalid", vv, 32'b11110);
    check_eq("single_done", dn, 32'b00001);
    check_eq("single_busy", bz, 32'b11110);
    check_eq("single_frame_cnt", 32'(frame_cnt), 1);

    // Two frames, gap of 2
    start_burst(SEQ_1101, 8'd2, 4'd2);
    capture(11, dv, vv, dn, bz);
    check_eq("gap_dout", dv, 32'b11010011010);
    check_eq("gap_dvalid", vv, 32'b11110011110);
    check_eq("gap_done", dn, 32'b00000000001);
    check_eq("gap_busy", bz, 32'b11111111110);
    check_eq("gap_frame_cnt", 32'(frame_cnt), 2);

    // Three frames back to back
    start_burst(SEQ_1101, 8'd3, 4'd0);
    capture(13, dv, vv, dn, bz);
    check_eq("b2b_dout", dv, 32'b1101110111010);
    check_eq("b2b_dvalid", vv, 32'b1111111111110);
    check_eq("b2b_done", dn, 32'b0000000000001);
    check_eq("b2b_frame_cnt", 32'(frame_cnt), 3);

    // rpt=0 behaves as rpt=1; start again in the very cycle done is high
    start_burst(SEQ_1101, 8'd0, 4'd0);
    capture(4, dv, vv, dn, bz);
    check_eq("rpt0_dout", dv, 32'b1101);
    check_eq("rpt0_done_now", 32'(done), 1);
    start_burst(4'b1011, 8'd1, 4'd0);
    capture(5, dv, vv, dn, bz);
    check_eq("chain_dout", dv, 32'b10110);
    check_eq("chain_done", dn, 32'b00001);
    check_eq("chain_frame_cnt", 32'(frame_cnt), 1);

    // Abort during 2nd frame's 3rd bit; start/pattern changes while busy are ignored
    start_burst(SEQ_1101, 8'd4, 4'd0);
    pattern = 4'b0000; rpt = 8'd1; gap = 4'd3; start = 1'b1;
    capture(6, dv, vv, dn, bz);
    start = 1'b0;
    check_eq("busy_ignore_dout", dv, 32'b110111);
    check_eq("busy_ignore_dvalid", vv, 32'b111111);
    check_eq("abort_bit3_dout", 32'(dout), 0);
    check_eq("abort_bit3_dvalid", 32'(dvalid), 1);
    abort = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_dvalid", 32'(dvalid), 0);
    check_eq("abort_done", 32'(done), 0);
    check_eq("abort_frame_cnt", 32'(frame_cnt), 1);
    pattern = SEQ_1101; start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("abort_start_busy", 32'(busy), 0);
    check_eq("abort_start_done", 32'(done), 0);
    @(negedge clk);
    check_eq("abort_start_dvalid", 32'(dvalid), 0);

    // Asynchronous reset in the middle of a gap
    start_burst(SEQ_1101, 8'd2, 4'd3);
    capture(5, dv, vv, dn, bz);
    check_eq("midgap_busy", 32'(busy), 1);
    check_eq("midgap_dvalid", 32'(dvalid), 0);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 0);
    check_eq("arst_frame_cnt", 32'(frame_cnt), 0);
    check_eq("arst_dvalid", 32'(dvalid), 0);
    @(negedge clk);
    check_eq("arst_done", 32'(done), 0);
    rst = 1'b1;
    @(negedge clk);
    start_burst(SEQ_1101, 8'd1, 4'd0);
    capture(5, dv, vv, dn, bz);
    check_eq("post_rst_dout", dv, 32'b11010);
    check_eq("post_rst_done", dn, 32'b00001);

    // Loopback into the 1101 checker: 5 frames, 1-cycle gap
    exp_det = '0;
    for (int k = 0; k < 5; k++) exp_det[27 - (4 + 5 * k)] = 1'b1;
    det_v   = '0;
    det_cnt = 0;
    start_burst(SEQ_1101, 8'd5, 4'd1);
    dn = '0;
    for (int i = 0; i < 28; i++) begin
      det_v = {det_v[30:0], det_q};
      dn    = {dn[30:0], done};
      if (det_q) det_cnt++;
      @(negedge clk);
    end
    check_eq("loop_det_count", 32'(det_cnt), 5);
    check_eq("loop_det_timing", det_v, exp_det);
    check_eq("loop_done", dn, 32'b0000000000000000000000001000);
    check_eq("loop_frame_cnt", 32'(frame_cnt), 5);

    // Maximum repeat count must finish without counter overflow
    start_burst(SEQ_1101, 8'd255, 4'd0);
    done_at = -1;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        done_at = i;
        break;
      end
      @(negedge clk);
    end
    check_eq("max_rpt_done_cycle", 32'(done_at), 1020);
    check_eq("max_rpt_frame_cnt", 32'(frame_cnt), 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
